// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: strobes one row at a time, debounces press and release,
// and hands each key to the consumer through a valid/ack holding register with overrun flag.
module keypad_scan #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned DB_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_col,
    input  logic       key_ack,
    output logic [3:0] o_row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic       overrun
);

    localparam int unsigned MAX_CNT = (SCAN_DIV > DB_CYCLES) ? SCAN_DIV : DB_CYCLES;
    localparam int unsigned CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t        state;
    logic [3:0]    col_meta;
    logic [3:0]    col_s;
    logic [1:0]    row_idx;
    logic [CW-1:0] cnt;
    logic [3:0]    pattern;
    logic [1:0]    key_col;

    logic [1:0]    next_row_c;
    logic [3:0]    next_row_mask_c;
    logic [1:0]    low_col_c;
    logic          issue_c;

    // Next row index and its active-low strobe pattern.
    always_comb begin
        next_row_c      = row_idx + 2'd1;
        next_row_mask_c = ~(4'b0001 << next_row_c);
    end

    // Lowest-index column pulled low on the frozen row.
    always_comb begin
        low_col_c = 2'd3;
        if (!col_s[0])      low_col_c = 2'd0;
        else if (!col_s[1]) low_col_c = 2'd1;
        else if (!col_s[2]) low_col_c = 2'd2;
    end

    assign issue_c = (state == DEBOUNCE) && (col_s == pattern) && (cnt == DB_LAST);

    // Synchronizer, scan/debounce FSM and row strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_meta <= 4'hF;
            col_s    <= 4'hF;
            state    <= SCAN;
            row_idx  <= 2'd0;
            o_row    <= 4'b1110;
            cnt      <= '0;
            pattern  <= 4'hF;
            key_col  <= 2'd0;
            key_down <= 1'b0;
        end else begin
            col_meta <= i_col;
            col_s    <= col_meta;
            case (state)
                SCAN: begin
                    if (cnt == DWELL_LAST) begin
                        cnt <= '0;
                        if (col_s != 4'hF) begin
                            pattern <= col_s;
                            key_col <= low_col_c;
                            state   <= DEBOUNCE;
                        end else begin
                            row_idx <= next_row_c;
                            o_row   <= next_row_mask_c;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (col_s != pattern) begin
                        cnt     <= '0;
                        row_idx <= next_row_c;
                        o_row   <= next_row_mask_c;
                        state   <= SCAN;
                    end else if (cnt == DB_LAST) begin
                        cnt      <= '0;
                        key_down <= 1'b1;
                        state    <= HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (col_s == 4'hF) begin
                        cnt   <= '0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (col_s != 4'hF) begin
                        cnt   <= '0;
                        state <= HOLD;
                    end else if (cnt == DB_LAST) begin
                        cnt      <= '0;
                        key_down <= 1'b0;
                        row_idx  <= next_row_c;
                        o_row    <= next_row_mask_c;
                        state    <= SCAN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    // Key holding register: an unacknowledged key is never overwritten; a lost key sets overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (issue_c) begin
            if (!key_valid || key_ack) begin
                key_code  <= {row_idx, key_col};
                key_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (key_ack && key_valid) begin
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a simple matrix model closing the row/column loop.
module tb_keypad_scan;

    logic       clk;
    logic       reset;
    logic [3:0] i_col;
    logic       key_ack;
    logic [3:0] o_row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic       overrun;

    logic       pressed;
    logic [1:0] prow;
    logic [1:0] pcol;

    int checks = 0;
    int errors = 0;
    int rises  = 0;
    int base   = 0;
    logic kv_q = 1'b0;

    keypad_scan #(.SCAN_DIV(4), .DB_CYCLES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_col     (i_col),
        .key_ack   (key_ack),
        .o_row     (o_row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: the pressed key pulls its column low while its row is strobed.
    always_comb begin
        i_col = 4'hF;
        if (pressed && !o_row[prow]) i_col = ~(4'b0001 << pcol);
    end

    // Count key_valid rising edges independently of the directed checks.
    always @(negedge clk) begin
        if (key_valid && !kv_q) rises = rises + 1;
        kv_q = key_valid;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_row(input logic [3:0] r);
        for (int i = 0; i < 200 && o_row !== r; i++) @(negedge clk);
        check("wait_row", 8'(o_row), 8'(r));
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 200 && key_valid !== 1'b1; i++) @(negedge clk);
        check("wait_valid", 8'(key_valid), 8'd1);
    endtask

    task automatic wait_down(input logic v);
        for (int i = 0; i < 200 && key_down !== v; i++) @(negedge clk);
        check("wait_down", 8'(key_down), 8'(v));
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        prow    = r;
        pcol    = c;
        pressed = 1'b1;
    endtask

    task automatic ack();
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        key_ack = 1'b0;
        pressed = 1'b0;
        prow    = 2'd0;
        pcol    = 2'd0;
        repeat (2) @(negedge clk);
        check("rst_row",     8'(o_row),     8'h0E);
        check("rst_valid",   8'(key_valid), 8'd0);
        check("rst_down",    8'(key_down),  8'd0);
        check("rst_code",    8'(key_code),  8'd0);
        check("rst_overrun", 8'(overrun),   8'd0);

        // Idle scan: each row strobed for 4 cycles, wrapping after row 3.
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            logic [3:0] exp_row;
            exp_row = ~(4'b0001 << ((i / 4) % 4));
            check("idle_row", 8'(o_row), 8'(exp_row));
            @(negedge clk);
        end
        check("idle_valid", 8'(key_valid), 8'd0);

        // Clean press row 2 col 1.
        press(2'd2, 2'd1);
        wait_valid();
        check("p9_code", 8'(key_code), 8'd9);
        check("p9_down", 8'(key_down), 8'd1);
        check("p9_row",  8'(o_row),    8'h0B);
        repeat (5) @(negedge clk);
        check("p9_row_frozen", 8'(o_row), 8'h0B);
        pressed = 1'b0;
        wait_down(1'b0);
        check("p9_valid_held", 8'(key_valid), 8'd1);
        check("p9_code_held",  8'(key_code),  8'd9);
        ack();
        check("p9_ack_valid", 8'(key_valid), 8'd0);
        ack();
        check("idle_ack_valid",   8'(key_valid), 8'd0);
        check("idle_ack_overrun", 8'(overrun),   8'd0);

        // Bounce during debounce, then a clean press: exactly one key.
        base = rises;
        press(2'd2, 2'd1);
        wait_row(4'b1011);
        repeat (4) @(negedge clk);
        pressed = 1'b0;
        @(negedge clk);
        pressed = 1'b1;
        @(negedge clk);
        pressed = 1'b0;
        @(negedge clk);
        pressed = 1'b1;
        check("bounce_valid", 8'(key_valid), 8'd0);
        check("bounce_down",  8'(key_down),  8'd0);
        wait_valid();
        check("bounce_code", 8'(key_code), 8'd9);
        pressed = 1'b0;
        wait_down(1'b0);
        repeat (40) @(negedge clk);
        check("bounce_one_key", 8'(rises - base), 8'd1);
        check("bounce_overrun", 8'(overrun),      8'd0);
        ack();

        // Two keys without ack: first retained, overrun set.
        press(2'd1, 2'd1);
        wait_valid();
        check("ov_first_code", 8'(key_code), 8'd5);
        pressed = 1'b0;
        wait_down(1'b0);
        press(2'd3, 2'd0);
        wait_down(1'b1);
        check("ov_overrun", 8'(overrun),   8'd1);
        check("ov_code",    8'(key_code),  8'd5);
        check("ov_valid",   8'(key_valid), 8'd1);
        pressed = 1'b0;
        wait_down(1'b0);
        ack();
        check("ov_ack_valid",   8'(key_valid), 8'd0);
        check("ov_ack_overrun", 8'(overrun),   8'd0);

        // Ack coincident with the second issue: new key loaded, no overrun.
        press(2'd1, 2'd1);
        wait_valid();
        check("co_first_code", 8'(key_code), 8'd5);
        pressed = 1'b0;
        wait_down(1'b0);
        press(2'd3, 2'd0);
        wait_row(4'b0111);
        repeat (11) @(negedge clk);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        check("co_code",    8'(key_code),  8'd12);
        check("co_valid",   8'(key_valid), 8'd1);
        check("co_overrun", 8'(overrun),   8'd0);
        check("co_down",    8'(key_down),  8'd1);
        pressed = 1'b0;
        wait_down(1'b0);
        ack();
        check("co_ack_valid", 8'(key_valid), 8'd0);

        // Reset in the middle of debounce.
        press(2'd2, 2'd1);
        wait_row(4'b1011);
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_row",     8'(o_row),     8'h0E);
        check("mid_rst_code",    8'(key_code),  8'd0);
        check("mid_rst_valid",   8'(key_valid), 8'd0);
        check("mid_rst_down",    8'(key_down),  8'd0);
        check("mid_rst_overrun", 8'(overrun),   8'd0);
        pressed = 1'b0;
        @(negedge clk);
        base  = rises;
        reset = 1'b0;
        check("post_rst_row", 8'(o_row), 8'h0E);
        repeat (60) @(negedge clk);
        check("post_rst_valid", 8'(key_valid),    8'd0);
        check("post_rst_rises", 8'(rises - base), 8'd0);
        press(2'd2, 2'd1);
        wait_valid();
        check("post_rst_code", 8'(key_code), 8'd9);
        pressed = 1'b0;
        wait_down(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
